backend_cfg_sequencer: RTL and testbench
========================================

// Module: backend_cfg_sequencer
// PURPOSE
//  FPGA-side controller that brings up the backend: holds backend reset, serially shifts a
//  gain configuration word (gainA1/gainA2 fields) over sclk/sdout, waits for ready, then
//  samples vco1_fast as the bring-up status. Drives the FPGA_model-facing pins of backend.
// PARAMETERS
//  CFG_W          5    config word width: [4:2]=gainA1, [1:0]=gainA2; shifted MSB first
//  SCLK_DIV       2    mainclk cycles per sclk half-period (>=1)
//  RST_CYCLES     8    cycles o_resetbAll is held low after start
//  READY_TIMEOUT  256  cycles to wait for synchronized ready before flagging timeout
// PORTS
//  i_mainclk      in   1      single clock; all logic on rising edge
//  i_reset        in   1      synchronous, active-high reset
//  i_start        in   1      1-cycle pulse; starts a bring-up sequence (ignored when busy)
//  i_cfg_word     in   CFG_W  config word, captured on accepted i_start
//  i_ready        in   1      backend ready (async to us; 2-flop synchronized inside)
//  i_vco1_fast    in   1      backend VCO1 comparison flag (2-flop synchronized inside)
//  o_resetbAll    out  1      active-low backend reset
//  o_sclk         out  1      serial config clock
//  o_sdout        out  1      serial config data
//  o_busy         out  1      high from accepted start until DONE/ERROR
//  o_done         out  1      1-cycle pulse on successful completion
//  o_timeout      out  1      sticky; set on ready timeout, cleared by next accepted start
//  o_vco1_fast_q  out  1      synchronized vco1_fast, latched at completion
//  o_cfg_applied  out  CFG_W  last word fully shifted out
// BEHAVIOUR
//  Reset values: o_resetbAll=0, o_sclk=0, o_sdout=0, o_busy=0, o_done=0, o_timeout=0,
//   o_vco1_fast_q=0, o_cfg_applied=0; FSM=IDLE; sync flops=0.
//  FSM: IDLE -> RST_HOLD -> SHIFT -> WAIT_RDY -> SAMPLE -> IDLE; WAIT_RDY -> ERROR -> IDLE.
//  IDLE: o_resetbAll=0. i_start: capture word, clear o_timeout, o_busy=1 next cycle.
//  RST_HOLD: o_resetbAll=0 for exactly RST_CYCLES cycles, then o_resetbAll=1 and go SHIFT.
//  SHIFT: sclk period 2*SCLK_DIV cycles, starts low. o_sdout updates only while sclk low,
//   at entry and on each sclk falling edge; stable across each rising edge. CFG_W rising
//   edges total; after the last high phase sclk returns low and stays low; o_sdout -> 0.
//   Total SHIFT duration = CFG_W*2*SCLK_DIV cycles. o_cfg_applied updated on exit.
//  WAIT_RDY: counter from 0; synchronized ready=1 -> SAMPLE. Counter reaching
//   READY_TIMEOUT-1 without ready -> ERROR. Ready already high on entry is accepted.
//  SAMPLE: one cycle; latch synced vco1_fast into o_vco1_fast_q, pulse o_done, -> IDLE.
//  ERROR: one cycle; set o_timeout, o_resetbAll=0, -> IDLE; no o_done.
//  o_busy deasserts in cycle after SAMPLE/ERROR. o_resetbAll stays 1 in IDLE after success.
//  i_start while busy: ignored, no effect on captured word. i_reset mid-sequence: all
//   outputs to reset values next edge, partial shift discarded, o_cfg_applied unchanged=0.
//  Synchronizer latency: 2 cycles from i_ready/i_vco1_fast to internal use.
// CONFIGURATION
//  BACKEND_AUTO_GAIN_EN defined: in SAMPLE, if synced vco1_fast=1 and gainA1 field !=0,
//   decrement gainA1 field and return to SHIFT (reset not re-asserted); at most 7 retries;
//   o_done when vco1_fast=0 or gainA1=0. Not defined: single shift, vco1_fast only reported.
// STRUCTURE
//  Package backend_cfg_pkg: FSM state enum, CFG field offsets (GAINA1_MSB/LSB, GAINA2_MSB/
//   LSB), default parameter constants.
//  Sub-module: cfg_serializer (load, CFG_W shift register, sclk divider, done strobe),
//   instantiated once; FSM, synchronizers, timeout counter in the top.
// TESTING
//  1 Start with cfg=5'b10110, ready tied 1 -> resetbAll low 8 cycles, sdout bits 1,0,1,1,0
//    at sclk rises, 5 sclk pulses of period 4, o_done pulse, o_cfg_applied=5'b10110.
//  2 ready held 0 -> o_timeout=1 after 256 WAIT_RDY cycles, resetbAll=0, no o_done.
//  3 i_start pulsed mid-SHIFT with different word -> ignored; shifted/applied word unchanged.
//  4 i_reset asserted mid-SHIFT -> next edge all outputs at reset values; new start works.
//  5 ready rises 20 cycles into WAIT_RDY, vco1_fast=1 -> o_done ~22 cycles later,
//    o_vco1_fast_q=1.
//  6 BACKEND_AUTO_GAIN_EN, cfg gainA1=3, vco1_fast=1 until second reshift -> words 3,2,1
//    shifted, o_done with o_cfg_applied gainA1=1; without macro only gainA1=3 shifted.

Source files
------------

// File: rtl/backend_cfg_pkg.sv
// Shared types and constants for the backend bring-up sequencer.
// Optional feature macro used by the top: BACKEND_AUTO_GAIN_EN.
package backend_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST_HOLD,
        ST_SHIFT,
        ST_WAIT_RDY,
        ST_SAMPLE,
        ST_ERROR
    } seq_state_t;

    localparam int unsigned GAINA1_MSB = 4;
    localparam int unsigned GAINA1_LSB = 2;
    localparam int unsigned GAINA2_MSB = 1;
    localparam int unsigned GAINA2_LSB = 0;

    localparam int unsigned DEF_CFG_W         = 5;
    localparam int unsigned DEF_SCLK_DIV      = 2;
    localparam int unsigned DEF_RST_CYCLES    = 8;
    localparam int unsigned DEF_READY_TIMEOUT = 256;
    localparam int unsigned MAX_GAIN_RETRIES  = 7;

endpackage

// File: rtl/cfg_serializer.sv
// MSB-first serializer: sclk starts low, data changes only while sclk is low,
// done strobes during the final high phase, after which sclk/sdout idle low.
module cfg_serializer #(
    parameter int unsigned CFG_W    = 5,
    parameter int unsigned SCLK_DIV = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CFG_W-1:0] word,
    output logic             sclk,
    output logic             sdout,
    output logic             done
);

    localparam int unsigned DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int unsigned BIT_W = (CFG_W > 1) ? $clog2(CFG_W) : 1;

    logic             active;
    logic [CFG_W-2:0] sreg;
    logic [DIV_W-1:0] div_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic             phase_end;
    logic             last_bit;

    assign phase_end = active && (div_cnt == DIV_W'(SCLK_DIV - 1));
    assign last_bit  = (bit_cnt == BIT_W'(CFG_W - 1));
    assign done      = phase_end && sclk && last_bit;

    // sreg holds only the bits not yet presented on sdout
    always_ff @(posedge clk) begin
        if (reset) begin
            active  <= 1'b0;
            sreg    <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
            sclk    <= 1'b0;
            sdout   <= 1'b0;
        end else if (load) begin
            active  <= 1'b1;
            sreg    <= word[CFG_W-2:0];
            sdout   <= word[CFG_W-1];
            sclk    <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (active) begin
            if (phase_end) begin
                div_cnt <= '0;
                if (!sclk) begin
                    sclk <= 1'b1;
                end else begin
                    sclk <= 1'b0;
                    if (last_bit) begin
                        active <= 1'b0;
                        sdout  <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        sdout   <= sreg[CFG_W-2];
                        sreg    <= sreg << 1;
                    end
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/backend_cfg_sequencer.sv
// Backend bring-up: reset hold, serial gain config, ready wait, vco1_fast sample.
// Define BACKEND_AUTO_GAIN_EN to step gainA1 down and reshift while vco1_fast is high.
module backend_cfg_sequencer
    import backend_cfg_pkg::*;
#(
    parameter int unsigned CFG_W         = DEF_CFG_W,
    parameter int unsigned SCLK_DIV      = DEF_SCLK_DIV,
    parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
    parameter int unsigned READY_TIMEOUT = DEF_READY_TIMEOUT
) (
    input  logic             i_mainclk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [CFG_W-1:0] i_cfg_word,
    input  logic             i_ready,
    input  logic             i_vco1_fast,
    output logic             o_resetbAll,
    output logic             o_sclk,
    output logic             o_sdout,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_timeout,
    output logic             o_vco1_fast_q,
    output logic [CFG_W-1:0] o_cfg_applied
);

    localparam int unsigned RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int unsigned TO_W = (READY_TIMEOUT > 1) ? $clog2(READY_TIMEOUT) : 1;

    seq_state_t       state, state_nxt;
    logic             rdy_s1, rdy_s2, vco_s1, vco_s2;
    logic [CFG_W-1:0] word_q;
    logic [CFG_W-1:0] ser_word;
    logic [RC_W-1:0]  rst_cnt;
    logic [TO_W-1:0]  wait_cnt;
    logic             ser_load, ser_done, retry;

`ifdef BACKEND_AUTO_GAIN_EN
    logic [2:0]       retry_cnt;
    logic [CFG_W-1:0] word_dec;

    always_comb begin
        word_dec = word_q;
        word_dec[GAINA1_MSB:GAINA1_LSB] = word_q[GAINA1_MSB:GAINA1_LSB] - 1'b1;
    end

    assign retry    = vco_s2 && (word_q[GAINA1_MSB:GAINA1_LSB] != '0)
                      && (retry_cnt != 3'(MAX_GAIN_RETRIES));
    assign ser_word = (state == ST_SAMPLE) ? word_dec : word_q;

    always_ff @(posedge i_mainclk) begin
        if (i_reset) begin
            retry_cnt <= '0;
        end else if (state == ST_IDLE && i_start) begin
            retry_cnt <= '0;
        end else if (state == ST_SAMPLE && retry) begin
            retry_cnt <= retry_cnt + 1'b1;
        end
    end
`else
    assign retry    = 1'b0;
    assign ser_word = word_q;
`endif

    always_ff @(posedge i_mainclk) begin
        if (i_reset) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (i_start) state_nxt = ST_RST_HOLD;
            ST_RST_HOLD: if (rst_cnt == RC_W'(RST_CYCLES - 1)) state_nxt = ST_SHIFT;
            ST_SHIFT:    if (ser_done) state_nxt = ST_WAIT_RDY;
            ST_WAIT_RDY: begin
                if (rdy_s2)                                   state_nxt = ST_SAMPLE;
                else if (wait_cnt == TO_W'(READY_TIMEOUT - 1)) state_nxt = ST_ERROR;
            end
            ST_SAMPLE:   state_nxt = retry ? ST_SHIFT : ST_IDLE;
            ST_ERROR:    state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy   = (state != ST_IDLE);
        o_done   = (state == ST_SAMPLE) && !retry;
        ser_load = ((state == ST_RST_HOLD) && (state_nxt == ST_SHIFT))
                   || ((state == ST_SAMPLE) && retry);
    end

    // Timeout and reset are asserted on entry to ERROR so they are visible during it
    always_ff @(posedge i_mainclk) begin
        if (i_reset) begin
            rdy_s1        <= 1'b0;
            rdy_s2        <= 1'b0;
            vco_s1        <= 1'b0;
            vco_s2        <= 1'b0;
            word_q        <= '0;
            rst_cnt       <= '0;
            wait_cnt      <= '0;
            o_resetbAll   <= 1'b0;
            o_timeout     <= 1'b0;
            o_vco1_fast_q <= 1'b0;
            o_cfg_applied <= '0;
        end else begin
            rdy_s1   <= i_ready;
            rdy_s2   <= rdy_s1;
            vco_s1   <= i_vco1_fast;
            vco_s2   <= vco_s1;
            rst_cnt  <= (state == ST_RST_HOLD) ? rst_cnt + 1'b1 : '0;
            wait_cnt <= (state == ST_WAIT_RDY) ? wait_cnt + 1'b1 : '0;
            case (state)
                ST_IDLE: if (i_start) begin
                    word_q      <= i_cfg_word;
                    o_timeout   <= 1'b0;
                    o_resetbAll <= 1'b0;
                end
                ST_RST_HOLD: if (state_nxt == ST_SHIFT) o_resetbAll <= 1'b1;
                ST_SHIFT:    if (ser_done) o_cfg_applied <= word_q;
                ST_WAIT_RDY: if (state_nxt == ST_ERROR) begin
                    o_timeout   <= 1'b1;
                    o_resetbAll <= 1'b0;
                end
                ST_SAMPLE: begin
                    if (retry) word_q <= ser_word;
                    else       o_vco1_fast_q <= vco_s2;
                end
                default: ;
            endcase
        end
    end

    cfg_serializer #(
        .CFG_W    (CFG_W),
        .SCLK_DIV (SCLK_DIV)
    ) u_serializer (
        .clk   (i_mainclk),
        .reset (i_reset),
        .load  (ser_load),
        .word  (ser_word),
        .sclk  (o_sclk),
        .sdout (o_sdout),
        .done  (ser_done)
    );

endmodule

// File: tb/tb_backend_cfg_sequencer.sv
// Randomized bench for backend_cfg_sequencer against a transaction-level model.
// Honours BACKEND_AUTO_GAIN_EN when the design is built with it.
module tb_backend_cfg_sequencer;

    localparam int CFG_W         = 5;
    localparam int SCLK_DIV      = 2;
    localparam int RST_CYCLES    = 8;
    localparam int READY_TIMEOUT = 256;
`ifdef BACKEND_AUTO_GAIN_EN
    localparam bit AUTO_GAIN = 1'b1;
`else
    localparam bit AUTO_GAIN = 1'b0;
`endif
    // cycle index (1 = first cycle after the start edge) of the first WAIT_RDY cycle
    localparam int WAIT_FIRST = 1 + RST_CYCLES + CFG_W * 2 * SCLK_DIV;
    localparam int WAIT_LAST  = WAIT_FIRST + READY_TIMEOUT - 1;
    localparam int RESHIFT    = 1 + CFG_W * 2 * SCLK_DIV + 1;

    logic             clk = 1'b0;
    logic             i_reset = 1'b1;
    logic             i_start = 1'b0;
    logic [CFG_W-1:0] i_cfg_word = '0;
    logic             i_ready = 1'b0;
    logic             i_vco1_fast = 1'b0;
    logic             o_resetbAll, o_sclk, o_sdout, o_busy, o_done, o_timeout, o_vco1_fast_q;
    logic [CFG_W-1:0] o_cfg_applied;

    int checks = 0;
    int errors = 0;

    logic [CFG_W-1:0] exp_applied = '0;
    logic             exp_vco_q   = 1'b0;

    always #5 clk = ~clk;

    backend_cfg_sequencer #(
        .CFG_W         (CFG_W),
        .SCLK_DIV      (SCLK_DIV),
        .RST_CYCLES    (RST_CYCLES),
        .READY_TIMEOUT (READY_TIMEOUT)
    ) dut (
        .i_mainclk     (clk),
        .i_reset       (i_reset),
        .i_start       (i_start),
        .i_cfg_word    (i_cfg_word),
        .i_ready       (i_ready),
        .i_vco1_fast   (i_vco1_fast),
        .o_resetbAll   (o_resetbAll),
        .o_sclk        (o_sclk),
        .o_sdout       (o_sdout),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_timeout     (o_timeout),
        .o_vco1_fast_q (o_vco1_fast_q),
        .o_cfg_applied (o_cfg_applied)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_resetbAll"}, o_resetbAll, 0);
        check_eq({tag, "_sclk"}, o_sclk, 0);
        check_eq({tag, "_sdout"}, o_sdout, 0);
        check_eq({tag, "_busy"}, o_busy, 0);
        check_eq({tag, "_done"}, o_done, 0);
        check_eq({tag, "_timeout"}, o_timeout, 0);
        check_eq({tag, "_vco_q"}, o_vco1_fast_q, 0);
        check_eq({tag, "_applied"}, o_cfg_applied, 0);
    endtask

    // rdy_d < 0: ready high throughout; otherwise ready rises rdy_d cycles into WAIT_RDY.
    // drop_at > 0: vco1_fast falls once that many sclk rises have been seen.
    task automatic run_txn(input logic [CFG_W-1:0] word, input int rdy_d, input bit vco,
                           input int drop_at, input bit mid_start);
        logic             exp_bits[$];
        logic             got_bits[$];
        int               rise_cyc[$];
        logic [CFG_W-1:0] w;
        logic             vco_k;
        int               retries, seen, exp_done, exp_idle;
        bit               success;
        int               n, first_high, done_cnt, done_cyc, stab_err, busy_low;
        logic             prev_sclk, prev_sdout;

        // model: whole-transaction outcome from the bring-up rules
        seen = (rdy_d < 0) ? WAIT_FIRST : ((WAIT_FIRST + rdy_d + 2 > WAIT_FIRST)
                                           ? WAIT_FIRST + rdy_d + 2 : WAIT_FIRST);
        success = (seen <= WAIT_LAST);
        w = word;
        retries = 0;
        vco_k = vco;
        for (int k = 0; k < 8; k++) begin
            for (int b = CFG_W - 1; b >= 0; b--) exp_bits.push_back(w[b]);
            vco_k = vco && !(drop_at > 0 && drop_at <= (k + 1) * CFG_W);
            if (!success || !(AUTO_GAIN && vco_k && w[4:2] != 3'd0 && retries < 7)) break;
            w[4:2] = w[4:2] - 3'd1;
            retries++;
        end
        exp_done = seen + 1 + RESHIFT * retries;
        exp_idle = success ? exp_done + 1 : WAIT_LAST + 2;

        i_ready     = (rdy_d < 0);
        i_vco1_fast = vco;
        i_cfg_word  = word;
        i_start     = 1'b1;
        prev_sclk   = o_sclk;
        prev_sdout  = o_sdout;
        n = 0; first_high = -1; done_cnt = 0; done_cyc = -1; stab_err = 0; busy_low = -1;
        while (n < 1000) begin
            @(negedge clk);
            n++;
            i_start = 1'b0;
            if (mid_start && n == 15) begin
                i_start    = 1'b1;
                i_cfg_word = ~word;
            end
            if (n == 1) check_eq("busy_after_start", o_busy, 1);
            if (first_high < 0 && o_resetbAll) first_high = n;
            if (o_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = n;
            end
            if (o_sclk && !prev_sclk) begin
                got_bits.push_back(o_sdout);
                rise_cyc.push_back(n);
                if (o_sdout !== prev_sdout) stab_err++;
                if (drop_at > 0 && got_bits.size() == drop_at) i_vco1_fast = 1'b0;
            end
            if (rdy_d >= 0 && n == WAIT_FIRST + rdy_d) i_ready = 1'b1;
            prev_sclk  = o_sclk;
            prev_sdout = o_sdout;
            if (!o_busy) begin
                busy_low = n;
                break;
            end
        end

        if (success) begin
            exp_applied = w;
            exp_vco_q   = vco_k;
        end else begin
            exp_applied = word;
        end

        check_eq("busy_bound", busy_low, exp_idle);
        check_eq("rst_release_cycle", first_high, 1 + RST_CYCLES);
        check_eq("bit_count", got_bits.size(), exp_bits.size());
        for (int i = 0; i < got_bits.size() && i < exp_bits.size(); i++)
            check_eq("sdout_bit", got_bits[i], exp_bits[i]);
        if (rise_cyc.size() > 0) check_eq("first_rise", rise_cyc[0], 1 + RST_CYCLES + SCLK_DIV);
        for (int i = 1; i < rise_cyc.size(); i++)
            if (i % CFG_W != 0) check_eq("sclk_period", rise_cyc[i] - rise_cyc[i-1], 2 * SCLK_DIV);
        check_eq("sdout_stable", stab_err, 0);
        check_eq("done_pulses", done_cnt, success ? 1 : 0);
        if (success) check_eq("done_cycle", done_cyc, exp_done);
        check_eq("timeout", o_timeout, !success);
        check_eq("resetbAll_idle", o_resetbAll, success);
        check_eq("cfg_applied", o_cfg_applied, exp_applied);
        check_eq("vco_q", o_vco1_fast_q, exp_vco_q);
        check_eq("sclk_idle", o_sclk, 0);
        check_eq("sdout_idle", o_sdout, 0);
        @(negedge clk);
    endtask

    initial begin
        int d;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        i_reset = 1'b0;
        @(negedge clk);

        // reset in the middle of a shift
        i_cfg_word = 5'b11011;
        i_ready    = 1'b1;
        i_start    = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (14) @(negedge clk);
        check_eq("mid_shift_busy", o_busy, 1);
        i_reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        i_reset = 1'b0;
        exp_applied = '0;
        exp_vco_q   = 1'b0;
        @(negedge clk);

        run_txn(5'b10110, -1, 1'b0, 0, 1'b0);
        run_txn(5'b01001, 5000, 1'b1, 0, 1'b0);
        run_txn(5'b11100, -1, 1'b0, 0, 1'b1);
        run_txn(5'b00111, 20, 1'b1, 0, 1'b0);
        run_txn(5'b01101, -1, 1'b1, 2 * CFG_W + 1, 1'b0);
        run_txn(5'b11110, 253, 1'b0, 0, 1'b0);
        run_txn(5'b10001, 254, 1'b1, 0, 1'b0);

        for (int t = 0; t < 10; t++) begin
            case ($urandom_range(0, 3))
                0:       d = -1;
                1:       d = $urandom_range(0, 40);
                2:       d = $urandom_range(250, 256);
                default: d = 5000;
            endcase
            run_txn(CFG_W'($urandom), d, 1'($urandom), 0, 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
